vga_line_buf: RTL and testbench
===============================

# vga_line_buf

Ping-pong line buffer that feeds RGB565 pixel data into the VGA timing stage. A producer (pattern generator or frame store reader) writes one 640-pixel line through a valid/ready stream. The block swaps banks at the start of each active line and reads pixels out on the timing stage's pixel strobe. The outputs drive `vga_r`/`vga_g`/`vga_b` directly; the timing stage still generates `vga_hsync`/`vga_vsync`.

## Interface
- `H_ACTIVE`, 640: pixels per active line; this is also the depth of each bank.
- `ADDR_W`, 10: bank address width; must satisfy 2^ADDR_W ≥ H_ACTIVE.
- `UNDERRUN_COLOR`, 16'hF81F: RGB565 value shown for a line with no valid data.

Ports:
- `clk_sys` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `pix_en` in 1: one-cycle pixel strobe, one every 4 `clk_sys` cycles.
- `line_start` in 1: one-cycle pulse once per line, at least 2 cycles before the first `h_de`.
- `frame_start` in 1: one-cycle pulse at the start of vsync.
- `h_de` in 1: horizontal active region.
- `v_de` in 1: vertical active region.
- `wr_valid` in 1: write beat valid.
- `wr_data` in 16: RGB565 pixel, packed as {r[4:0], g[5:0], b[4:0]}.
- `wr_sof` in 1: qualifies the current beat as pixel 0 of a line.
- `wr_ready` out 1: block can accept a beat.
- `clr_err` in 1: clears `underrun`.
- `underrun` out 1: sticky flag; a line started with no full bank.
- `vga_r` out 5, `vga_g` out 6, `vga_b` out 5: pixel colour outputs.

## Operation
- **Storage:** two banks, each H_ACTIVE×16. `fill_sel` selects the bank being written; the other bank is the display bank.
- **Write FSM states:** W_FILL and W_FULL.
  - A beat is accepted on `wr_valid & wr_ready`. `wr_ready` = (state == W_FILL).
  - W_FILL: each accepted beat writes `wr_data` to `fill[wr_cnt]`, then `wr_cnt++`.
  - When the beat at `wr_cnt == H_ACTIVE-1` is accepted: go to W_FULL and set `wr_cnt = 0`.
  - An accepted beat with `wr_sof = 1` always writes to address 0 and sets `wr_cnt = 1`. This realigns a misaligned producer. The partial line is discarded and no error is raised.
  - W_FULL: wait for a swap.
- **Swap:** evaluated on `line_start & v_de`.
  - If the fill bank is full (state W_FULL, or the final beat is accepted in the same cycle): toggle `fill_sel`, set `disp_valid = 1`, and return to W_FILL with `wr_cnt = 0`.
  - Otherwise: set `disp_valid = 0` and `underrun = 1`. Filling continues unaffected.
- **Outside the active region:** `line_start` while `v_de = 0` causes no swap and no underrun. `frame_start` clears `disp_valid` and `rd_addr` only.
- **Read path:**
  - `line_start` sets `rd_addr = 0`.
  - On `pix_en & h_de & v_de`: read `disp[rd_addr]`, then `rd_addr++`. The increment saturates at H_ACTIVE-1, so any extra pixels repeat the last pixel.
- **Output colour**, registered and updated only in the cycle chosen by the pix_en pipeline:
  - Active with `disp_valid = 1`: the RAM word.
  - Active with `disp_valid = 0`: `UNDERRUN_COLOR`.
  - Not active at the strobe: 0.
  - Field mapping: r = [15:11], g = [10:5], b = [4:0].
- **Error flag:** `underrun` is cleared by `clr_err`. If set and clear occur in the same cycle, set wins.

## Timing
- **Reset (next edge after `rst` = 1):**
  - `vga_r`/`vga_g`/`vga_b` = 0, `underrun` = 0, `wr_ready` = 1.
  - `fill_sel` = 0, W_FILL, `wr_cnt` = 0, `disp_valid` = 0, `rd_addr` = 0.
  - RAM contents are not cleared.
- **Reset during a line:** the same reset values apply immediately. The next line underruns unless the producer writes a complete line first.
- **Read latency:** the RGB outputs update exactly 2 `clk_sys` cycles after `pix_en` (1 cycle synchronous RAM read + 1 cycle output register). They then hold steady until the next update, 4 cycles later.
- **Write throughput:** one beat per cycle.
  - `wr_ready` falls in the cycle after the final beat is accepted.
  - `wr_ready` rises in the cycle after the swap.
  - Write/read collision on a bank is impossible by construction.
- **Swap timing:** the swap takes effect on the `line_start` edge. The first active `pix_en` reads the new display bank.
- **Simultaneous `wr_sof` and final beat:** `wr_sof` takes priority (write to address 0, stay in W_FILL).

## Test plan
- **Basic fill and display:** reset, write 640 beats with `wr_data = index`, pulse `line_start` with `v_de = 1`, then 640 active `pix_en`.
  - Required: RGB outputs equal {index[15:11], index[10:5], index[4:0]}, each 2 cycles after its strobe. `wr_ready` drops after beat 639 and returns after the swap.
- **Underrun:** `line_start` with `v_de = 1` and no writes.
  - Required: active pixels output r = 5'h1F, g = 0, b = 5'h1F. `underrun` = 1 until `clr_err`. Assert `clr_err` and a new underrun in the same cycle: `underrun` stays 1.
- **Realign:** write 100 beats, then a beat with `wr_sof = 1` and data 16'hFFFF, then 639 more beats.
  - Required: state is W_FULL. The displayed pixel 0 is all ones. Total accepted = 740 beats.
- **Swap race:** final beat accepted in the same cycle as `line_start`.
  - Required: swap occurs and `underrun` stays 0.
- **Blanking and saturation:** extend `h_de` by 10 extra strobes, pulse `line_start` with `v_de = 0`, and leave `h_de = 0` at a strobe.
  - Required: the extra strobes repeat pixel 639. No swap and no underrun. The output is 0 when `h_de = 0` at the strobe.
- **Mid-line reset:** assert `rst` at pixel 300.
  - Required: outputs are 0 the next cycle and `wr_ready` = 1. The next active line shows `UNDERRUN_COLOR` unless a full line is written first.

Source files
------------

// File: rtl/vga_line_buf_if.sv
// Write-side pixel stream into the VGA line buffer: valid/ready beats of
// RGB565 pixels with a start-of-line qualifier.
interface vga_line_buf_if;
   logic        wr_valid;
   logic [15:0] wr_data;
   logic        wr_sof;
   logic        wr_ready;

   modport master (output wr_valid, output wr_data, output wr_sof, input wr_ready);
   modport slave  (input wr_valid, input wr_data, input wr_sof, output wr_ready);
endinterface

// File: rtl/vga_line_buf.sv
// Ping-pong RGB565 line buffer between a pixel producer and the VGA timing
// stage. One bank fills from the write stream while the other is scanned out
// on the pixel strobe; banks swap on line_start once the fill bank is full.
module vga_line_buf #(
   parameter int          H_ACTIVE       = 640,
   parameter int          ADDR_W         = 10,
   parameter logic [15:0] UNDERRUN_COLOR = 16'hF81F
) (
   input  logic           clk_sys,
   input  logic           rst,
   input  logic           pix_en,
   input  logic           line_start,
   input  logic           frame_start,
   input  logic           h_de,
   input  logic           v_de,
   input  logic           clr_err,
   vga_line_buf_if.slave  wr,
   output logic           underrun,
   output logic [4:0]     vga_r,
   output logic [5:0]     vga_g,
   output logic [4:0]     vga_b
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_ACTIVE - 1);

   typedef enum logic {W_FILL = 1'b0, W_FULL = 1'b1} wstate_e;

   wstate_e           state_q;
   logic [ADDR_W-1:0] wr_cnt_q;
   logic              wr_ready_q;
   logic              fill_sel_q;
   logic              disp_valid_q;
   logic              underrun_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [15:0]       rd_data_q;
   logic              pix_q, act_q, dv_q;
   logic [15:0]       rgb_q, rgb_d;

   logic [15:0] mem_q [2][H_ACTIVE];

   logic              wr_acc;
   logic              last_beat;
   logic              swap_ev;
   logic              full_now;
   logic              rd_en;
   logic [ADDR_W-1:0] wr_addr;

   assign wr_acc    = wr.wr_valid & wr_ready_q;
   // A start-of-line beat never completes a line, even at the last address.
   assign last_beat = wr_acc & ~wr.wr_sof & (state_q == W_FILL) & (wr_cnt_q == LAST);
   assign swap_ev   = line_start & v_de;
   assign full_now  = (state_q == W_FULL) | last_beat;
   assign rd_en     = pix_en & h_de & v_de;
   assign wr_addr   = wr.wr_sof ? '0 : wr_cnt_q;

   assign wr.wr_ready = wr_ready_q;
   assign underrun    = underrun_q;
   assign vga_r       = rgb_q[15:11];
   assign vga_g       = rgb_q[10:5];
   assign vga_b       = rgb_q[4:0];

   // Bank storage: write into the fill bank, read the display bank on the strobe.
   always_ff @(posedge clk_sys) begin
      if (wr_acc)
         mem_q[fill_sel_q][wr_addr] <= wr.wr_data;
      if (rd_en)
         rd_data_q <= mem_q[~fill_sel_q][rd_addr_q];
   end

   // Write FSM plus bank swap; a swap on the final beat's cycle still counts as full.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q      <= W_FILL;
         wr_cnt_q     <= '0;
         wr_ready_q   <= 1'b1;
         fill_sel_q   <= 1'b0;
         disp_valid_q <= 1'b0;
      end else begin
         if (frame_start)
            disp_valid_q <= 1'b0;
         case (state_q)
            W_FILL: begin
               if (wr_acc) begin
                  if (wr.wr_sof) begin
                     wr_cnt_q <= ADDR_W'(1);
                  end else if (wr_cnt_q == LAST) begin
                     state_q    <= W_FULL;
                     wr_ready_q <= 1'b0;
                     wr_cnt_q   <= '0;
                  end else begin
                     wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
                  end
               end
            end
            default: ;
         endcase
         if (swap_ev) begin
            if (full_now) begin
               fill_sel_q   <= ~fill_sel_q;
               disp_valid_q <= 1'b1;
               state_q      <= W_FILL;
               wr_ready_q   <= 1'b1;
               wr_cnt_q     <= '0;
            end else begin
               disp_valid_q <= 1'b0;
            end
         end
      end
   end

   // Sticky underrun flag; a new underrun beats a simultaneous clear.
   always_ff @(posedge clk_sys) begin
      if (rst)
         underrun_q <= 1'b0;
      else if (swap_ev && !full_now)
         underrun_q <= 1'b1;
      else if (clr_err)
         underrun_q <= 1'b0;
   end

   // Read address: rewinds each line/frame, saturates so overscan repeats the last pixel.
   always_ff @(posedge clk_sys) begin
      if (rst)
         rd_addr_q <= '0;
      else if (line_start || frame_start)
         rd_addr_q <= '0;
      else if (rd_en && rd_addr_q != LAST)
         rd_addr_q <= rd_addr_q + ADDR_W'(1);
   end

   // Strobe pipeline: carry strobe, activity and bank validity alongside the RAM read.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         pix_q <= 1'b0;
         act_q <= 1'b0;
         dv_q  <= 1'b0;
      end else begin
         pix_q <= pix_en;
         act_q <= rd_en;
         dv_q  <= disp_valid_q;
      end
   end

   // Output colour selection for the strobe now leaving the RAM stage.
   always_comb begin
      rgb_d = 16'h0000;
      if (act_q)
         rgb_d = dv_q ? rd_data_q : UNDERRUN_COLOR;
   end

   // Output register, updated only two cycles after each strobe.
   always_ff @(posedge clk_sys) begin
      if (rst)
         rgb_q <= 16'h0000;
      else if (pix_q)
         rgb_q <= rgb_d;
   end

endmodule

// File: tb/tb_vga_line_buf.sv
// Directed bench for vga_line_buf: fill/display, underrun, realign,
// swap race, blanking/saturation, frame_start and mid-line reset.
module tb_vga_line_buf;

   logic clk_sys = 1'b0;
   logic rst = 1'b1;
   logic pix_en = 1'b0, line_start = 1'b0, frame_start = 1'b0;
   logic h_de = 1'b0, v_de = 1'b0, clr_err = 1'b0;
   logic underrun;
   logic [4:0] vga_r;
   logic [5:0] vga_g;
   logic [4:0] vga_b;
   wire  [15:0] rgb = {vga_r, vga_g, vga_b};

   int n_err = 0;
   int n_chk = 0;
   int acc_cnt = 0;
   logic [15:0] prev_rgb = 16'h0000;

   vga_line_buf_if wif ();

   vga_line_buf dut (
      .clk_sys(clk_sys), .rst(rst), .pix_en(pix_en), .line_start(line_start),
      .frame_start(frame_start), .h_de(h_de), .v_de(v_de), .clr_err(clr_err),
      .wr(wif.slave), .underrun(underrun), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys)
      if (!rst && wif.wr_valid && wif.wr_ready) acc_cnt <= acc_cnt + 1;

   task automatic step();
      @(posedge clk_sys); #1;
   endtask

   task automatic write_beats(input int n, input logic [15:0] base, input logic sof_first);
      for (int i = 0; i < n; i++) begin
         wif.wr_valid = 1'b1;
         wif.wr_data  = base + 16'(i);
         wif.wr_sof   = sof_first && (i == 0);
         step();
      end
      wif.wr_valid = 1'b0;
      wif.wr_sof   = 1'b0;
   endtask

   task automatic pulse_ls(input logic vde);
      v_de = vde; line_start = 1'b1;
      step();
      line_start = 1'b0;
   endtask

   // One strobe: output must hold one cycle later and update two cycles later.
   task automatic strobe(input logic hde, input logic [15:0] exp, input string name);
      h_de = hde; pix_en = 1'b1;
      step();
      pix_en = 1'b0;
      n_chk++;
      if (rgb !== prev_rgb) begin
         n_err++; $display("FAIL %s_hold: got %h exp %h", name, rgb, prev_rgb);
      end
      step();
      n_chk++;
      if (rgb !== exp) begin
         n_err++; $display("FAIL %s: got %h exp %h", name, rgb, exp);
      end
      prev_rgb = exp;
      step(); step();
   endtask

   task automatic chk1(input logic got, input logic exp, input string name);
      n_chk++;
      if (got !== exp) begin
         n_err++; $display("FAIL %s: got %b exp %b", name, got, exp);
      end
   endtask

   task automatic test_reset();
      wif.wr_valid = 1'b0; wif.wr_data = 16'h0; wif.wr_sof = 1'b0;
      rst = 1'b1; step(); step();
      n_chk++;
      if (rgb !== 16'h0000) begin n_err++; $display("FAIL reset_rgb: got %h exp 0000", rgb); end
      chk1(underrun, 1'b0, "reset_underrun");
      chk1(wif.wr_ready, 1'b1, "reset_ready");
      rst = 1'b0; step();
   endtask

   task automatic test_basic();
      write_beats(639, 16'h0000, 1'b0);
      chk1(wif.wr_ready, 1'b1, "basic_ready_before_last");
      write_beats(1, 16'd639, 1'b0);
      chk1(wif.wr_ready, 1'b0, "basic_ready_after_last");
      step();
      pulse_ls(1'b1);
      chk1(wif.wr_ready, 1'b1, "basic_ready_after_swap");
      chk1(underrun, 1'b0, "basic_no_underrun");
      step();
      for (int i = 0; i < 640; i++) strobe(1'b1, 16'(i), "basic_pix");
      h_de = 1'b0;
   endtask

   task automatic test_underrun();
      pulse_ls(1'b1);
      chk1(underrun, 1'b1, "ur_set");
      step();
      for (int i = 0; i < 3; i++) strobe(1'b1, 16'hF81F, "ur_pix");
      h_de = 1'b0;
      step(); step();
      chk1(underrun, 1'b1, "ur_sticky");
      clr_err = 1'b1; line_start = 1'b1; v_de = 1'b1;
      step();
      clr_err = 1'b0; line_start = 1'b0;
      chk1(underrun, 1'b1, "ur_set_beats_clr");
      clr_err = 1'b1; step(); clr_err = 1'b0;
      chk1(underrun, 1'b0, "ur_cleared");
   endtask

   // Realigned line is displayed, then overscan and blanking strobes.
   task automatic test_realign_blank();
      acc_cnt = 0;
      step();
      write_beats(100, 16'h1000, 1'b0);
      write_beats(1, 16'hFFFF, 1'b1);
      write_beats(639, 16'h2001, 1'b0);
      n_chk++;
      if (acc_cnt != 740) begin n_err++; $display("FAIL realign_count: got %0d exp 740", acc_cnt); end
      chk1(wif.wr_ready, 1'b0, "realign_full");
      chk1(underrun, 1'b0, "realign_no_underrun");
      pulse_ls(1'b1);
      step();
      for (int i = 0; i < 640; i++)
         strobe(1'b1, (i == 0) ? 16'hFFFF : 16'h2000 + 16'(i), "realign_pix");
      for (int i = 0; i < 10; i++) strobe(1'b1, 16'h227F, "sat_pix");
      strobe(1'b0, 16'h0000, "blank_pix");
      chk1(underrun, 1'b0, "blank_no_underrun");
   endtask

   task automatic test_swap_race();
      write_beats(639, 16'h3000, 1'b0);
      pulse_ls(1'b0);
      chk1(underrun, 1'b0, "vde0_no_underrun");
      chk1(wif.wr_ready, 1'b1, "vde0_still_filling");
      step();
      wif.wr_valid = 1'b1; wif.wr_data = 16'h327F; wif.wr_sof = 1'b0;
      line_start = 1'b1; v_de = 1'b1;
      step();
      wif.wr_valid = 1'b0; line_start = 1'b0;
      chk1(wif.wr_ready, 1'b1, "race_swapped_ready");
      chk1(underrun, 1'b0, "race_no_underrun");
      step();
      for (int i = 0; i < 3; i++) strobe(1'b1, 16'h3000 + 16'(i), "race_pix");
      h_de = 1'b0;
      frame_start = 1'b1; step(); frame_start = 1'b0;
      strobe(1'b1, 16'hF81F, "fs_invalid_pix");
      h_de = 1'b0;
      chk1(underrun, 1'b0, "fs_no_underrun");
   endtask

   task automatic test_midline_reset();
      write_beats(640, 16'h4000, 1'b0);
      pulse_ls(1'b1);
      step();
      for (int i = 0; i < 300; i++) strobe(1'b1, 16'h4000 + 16'(i), "ml_pix");
      rst = 1'b1; step(); rst = 1'b0;
      h_de = 1'b0;
      n_chk++;
      if (rgb !== 16'h0000) begin n_err++; $display("FAIL ml_rgb_reset: got %h exp 0000", rgb); end
      chk1(wif.wr_ready, 1'b1, "ml_ready_reset");
      chk1(underrun, 1'b0, "ml_underrun_reset");
      prev_rgb = 16'h0000;
      step();
      pulse_ls(1'b1);
      chk1(underrun, 1'b1, "ml_next_underrun");
      step();
      for (int i = 0; i < 2; i++) strobe(1'b1, 16'hF81F, "ml_ur_pix");
      h_de = 1'b0;
      clr_err = 1'b1; step(); clr_err = 1'b0;
      write_beats(640, 16'h5000, 1'b0);
      pulse_ls(1'b1);
      chk1(underrun, 1'b0, "ml_refill_no_underrun");
      step();
      for (int i = 0; i < 2; i++) strobe(1'b1, 16'h5000 + 16'(i), "ml_refill_pix");
      h_de = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underrun();
      test_realign_blank();
      test_swap_race();
      test_midline_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
